// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared types and constants for the RISC-V core front end.
//   XLEN          : architectural register / address width
//   INST_BYTES    : bytes per instruction word (fetch stride)
//   fetch_entry_t : one buffered fetch result {pc, inst}
//   word_align()  : clears the byte-offset bits of an address
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// fetch_buffer
// Two-entry synchronous FIFO of fetch_entry_t holding returned instruction
// words until decode accepts them. The head is read straight from the
// storage registers, so a pushed word becomes visible the cycle after push.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : drop the head entry (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop in the same cycle
//   occ         : number of valid entries (0..2)
//   head        : oldest entry (all-zero after reset)
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   occ,
  output fetch_entry_t head
);

  fetch_entry_t entry_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   occ_reg;

  logic push_en;
  logic pop_en;

  assign push_en = push && !flush;
  assign pop_en  = pop && !flush && (occ_reg != 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg[gi] <= '0;
        end else if (push_en && (wr_ptr_reg == 1'(gi))) begin
          entry_reg[gi] <= push_entry;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg ^ push_en;
      rd_ptr_reg <= rd_ptr_reg ^ pop_en;
      occ_reg    <= occ_reg + {1'b0, push_en} - {1'b0, pop_en};
    end
  end

  assign occ  = occ_reg;
  assign head = entry_reg[rd_ptr_reg];

`ifndef SYNTHESIS
  // The issue rule upstream guarantees a slot for every response.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_en && !pop_en && (occ_reg == 2'd2)));
`endif

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Owns the program counter, issues word fetches over a grant/valid
// handshake, buffers returned words in a 2-entry FIFO and hands them to
// decode with valid/ready. A redirect reloads the PC, flushes the FIFO and
// arranges for every response still in flight to be discarded.
// Optional feature macro: IFU_STATS_EN adds fetch_count / flush_count.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_req/addr/gnt          : fetch request, word address, acceptance
//   imem_rvalid/rdata          : in-order response, one per grant
//   redirect_valid/redirect_pc : taken branch and its target
//   inst_valid/ready           : decode handshake
//   inst, inst_pc              : instruction word and its address
//   fetch_count, flush_count   : (IFU_STATS_EN only) handshake / redirect counters
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef IFU_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic [1:0]      out_reg, out_next;
  logic [1:0]      drop_reg, drop_next;

  logic            deq;
  logic            grant;
  logic [2:0]      in_flight;
  logic [XLEN-1:0] rsp_addr;

  logic            fb_push;
  fetch_entry_t    fb_push_entry;
  logic [1:0]      fb_occ;
  fetch_entry_t    fb_head;

  always_comb begin
    inst_valid = (fb_occ != 2'd0) && !redirect_valid;
    deq        = inst_valid && inst_ready;
    in_flight  = {1'b0, out_reg} + {1'b0, fb_occ} - {2'b00, deq};
    // rst_n gating keeps the request low for the whole reset period.
    imem_req   = rst_n && !redirect_valid && (in_flight < 3'd2);
    imem_addr  = pc_reg;
    grant      = imem_req && imem_gnt;

    // Live (non-dropped) requests are consecutive words ending at pc - 4,
    // and drops always come first, so the oldest outstanding request sits
    // out words below pc.
    rsp_addr   = pc_reg - {{(XLEN-4){1'b0}}, out_reg, 2'b00};

    fb_push            = imem_rvalid && (drop_reg == 2'd0) && !redirect_valid;
    fb_push_entry.pc   = rsp_addr;
    fb_push_entry.inst = imem_rdata;

    out_next = out_reg + {1'b0, grant} - {1'b0, imem_rvalid};

    drop_next = drop_reg;
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old path.
      drop_next = out_next;
    end else if (imem_rvalid && (drop_reg != 2'd0)) begin
      drop_next = drop_reg - 2'd1;
    end

    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = word_align(redirect_pc);
    end else if (grant) begin
      pc_next = pc_reg + XLEN'(INST_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg   <= RESET_PC;
      out_reg  <= 2'd0;
      drop_reg <= 2'd0;
    end else begin
      pc_reg   <= pc_next;
      out_reg  <= out_next;
      drop_reg <= drop_next;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fb_push),
    .push_entry (fb_push_entry),
    .pop        (deq),
    .flush      (redirect_valid),
    .occ        (fb_occ),
    .head       (fb_head)
  );

  assign inst    = fb_head.inst;
  assign inst_pc = fb_head.pc;

`ifdef IFU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (deq) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect_valid) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Responses never outnumber grants.
  a_rvalid_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (out_reg == 2'd0)));
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
// Table-driven check of instruction_fetch_unit. Each row drives one cycle of
// inputs (redirect, ready, grant, response enable) and lists the outputs
// expected in that cycle. A small in-order memory model returns one word per
// grant when its response enable is set; word(a) = a ^ 32'hDEAD_0000.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef IFU_STATS_EN
  logic [31:0] fetch_count;
  logic [15:0] flush_count;
`endif

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef IFU_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdv;
    logic [31:0] rpc;
    logic        rdy;
    logic        gnt;
    logic        rsp;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] pend[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          exp_fetch = 0;
  int          exp_flush = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic vec_t mk(input logic rdv, input logic [31:0] rpc,
                              input logic rdy, input logic gnt, input logic rsp,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_val, input logic [31:0] e_pc);
    vec_t v;
    v.rdv = rdv; v.rpc = rpc; v.rdy = rdy; v.gnt = gnt; v.rsp = rsp;
    v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check 1 ns later, then let the
  // memory model consume the rising edge.
  task automatic step(input vec_t v, input int idx);
    logic        took;
    logic        rv;
    logic [31:0] a;
    @(negedge clk);
    redirect_valid = v.rdv;
    redirect_pc    = v.rpc;
    inst_ready     = v.rdy;
    imem_gnt       = v.gnt;
    imem_rvalid    = v.rsp && (pend.size() > 0);
    imem_rdata     = imem_rvalid ? word_of(pend[0]) : 32'h0;
    #1;
    chk("imem_req", idx, {31'b0, imem_req}, {31'b0, v.e_req});
    if (v.e_req) chk("imem_addr", idx, imem_addr, v.e_addr);
    chk("inst_valid", idx, {31'b0, inst_valid}, {31'b0, v.e_val});
    if (v.e_val) begin
      chk("inst_pc", idx, inst_pc, v.e_pc);
      chk("inst", idx, inst, word_of(v.e_pc));
    end
    if (v.e_val && v.rdy && !v.rdv) exp_fetch++;
    if (v.rdv) exp_flush++;
    took = imem_req && imem_gnt;
    rv   = imem_rvalid;
    a    = imem_addr;
    @(posedge clk);
    if (rv) void'(pend.pop_front());
    if (took) pend.push_back(a);
  endtask

  task automatic check_reset_outputs(input int idx);
    chk("rst imem_req", idx, {31'b0, imem_req}, 32'd0);
    chk("rst imem_addr", idx, imem_addr, 32'h0);
    chk("rst inst_valid", idx, {31'b0, inst_valid}, 32'd0);
    chk("rst inst", idx, inst, 32'h0);
    chk("rst inst_pc", idx, inst_pc, 32'h0);
`ifdef IFU_STATS_EN
    chk("rst fetch_count", idx, fetch_count, 32'd0);
    chk("rst flush_count", idx, {16'b0, flush_count}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;

    // rdv rpc rdy gnt rsp | req addr | val pc
    // streaming from reset, one instruction per cycle
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h000, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h004, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h008, 1, 32'h000));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h00C, 1, 32'h004));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h010, 1, 32'h008));
    // decode stalled 10 cycles: requests stop at two outstanding/buffered
    for (int i = 0; i < 10; i++) vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 32'h00C));
    // release: no loss, no duplicates
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h014, 1, 32'h00C));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h018, 1, 32'h010));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h01C, 1, 32'h014));
    // hold responses so two requests (0x1C, 0x20) are in flight
    vq.push_back(mk(0, 0, 1, 1, 0, 1, 32'h020, 1, 32'h018));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    // redirect to 0x100 with two in flight; both stale words dropped
    vq.push_back(mk(1, 32'h100, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h100, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h104, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h108, 1, 32'h100));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h10C, 1, 32'h104));
    // redirect coincides with a response and a ready decode stage
    vq.push_back(mk(1, 32'h040, 1, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h040, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h044, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h048, 1, 32'h040));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h04C, 1, 32'h044));
    // back-to-back redirects: 0x200 then 0x303 (fetches 0x300)
    vq.push_back(mk(1, 32'h200, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 32'h303, 1, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h300, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h304, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h308, 1, 32'h300));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h30C, 1, 32'h304));
    // grant withheld: address holds steady
    vq.push_back(mk(0, 0, 1, 0, 1, 1, 32'h310, 1, 32'h308));
    vq.push_back(mk(0, 0, 1, 0, 1, 1, 32'h310, 1, 32'h30C));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h310, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h314, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h318, 1, 32'h310));
    // redirect to top of memory: fetch address wraps to zero
    vq.push_back(mk(1, 32'hFFFF_FFFE, 1, 1, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'hFFFF_FFFC, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h000, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h004, 1, 32'hFFFF_FFFC));
    vq.push_back(mk(0, 0, 1, 1, 1, 1, 32'h008, 1, 32'h000));
    // stall to fill the FIFO before the mid-stream reset
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 32'h004));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 32'h004));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs(-1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) step(vq[i], i);

`ifdef IFU_STATS_EN
    #2;
    chk("fetch_count", vq.size(), fetch_count, 32'(exp_fetch));
    chk("flush_count", vq.size(), {16'b0, flush_count}, 32'(exp_flush));
`endif

    // asynchronous reset with the FIFO full: outputs clear at once
    #2;
    inst_ready = 1'b1;
    rst_n      = 1'b0;
    #1;
    check_reset_outputs(-2);
    pend.delete();
    imem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(mk(0, 0, 1, 1, 1, 1, 32'h000, 0, 0), 1000);
    step(mk(0, 0, 1, 1, 1, 1, 32'h004, 0, 0), 1001);
    step(mk(0, 0, 1, 1, 1, 1, 32'h008, 1, 32'h000), 1002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch unit for the single-cycle RISC-V core. It owns the program counter and issues word requests to instruction memory over a grant/valid handshake. It buffers returned words in a 2-entry queue and presents them to the decode/control stage with a valid/ready handshake. A taken branch (BranchEqual plus target) redirects the PC, flushes the queue and discards in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  fetch request valid
- imem_addr  output  32  word-aligned fetch address
- imem_gnt  input  1  request accepted this cycle (only meaningful with imem_req)
- imem_rvalid  input  1  response data valid; responses in order, one per grant, ≥1 cycle after grant
- imem_rdata  input  32  instruction word
- redirect_valid  input  1  taken branch/jump this cycle
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced to 0)
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst  output  32  instruction word
- inst_pc  output  32  address of inst

## Operation
- State: pc (next address to request), outstanding count out ∈ {0,1,2}, drop count drop ∈ {0,1,2}, 2-entry FIFO of {pc, inst}, occupancy occ.
- Issue rule: imem_req = !redirect_valid && (out + occ − deq < 2), where deq = inst_valid && inst_ready. imem_addr = pc. On imem_req && imem_gnt: pc ← pc + 4, out increments.
- Response: on imem_rvalid, out decrements. If drop > 0, the word is discarded and drop decrements. Otherwise {address of that request, imem_rdata} is pushed to the FIFO. The FIFO never overflows under the issue rule; overflow is a design error flagged by assertion.
- Output: inst/inst_pc/inst_valid driven from FIFO head. inst_valid is forced low while redirect_valid = 1, so no handshake completes in a redirect cycle.
- Redirect (redirect_valid = 1):
  - pc ← {redirect_pc[31:2], 2'b00}; FIFO cleared.
  - drop ← out after this cycle's updates. A response arriving in the redirect cycle is itself dropped and not counted.
  - imem_req = 0 in the redirect cycle; the first request to the target is issued next cycle.
- Back-to-back redirects: the last one wins. drop accumulates correctly and never exceeds 2.
- Address arithmetic wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Reset, including mid-transaction: pc = RESET_PC, out = drop = occ = 0, imem_req = 0, inst_valid = 0, inst = 0, inst_pc = 0. Responses to pre-reset requests are the memory's responsibility to squash.

## Timing
- First imem_req = 1 with imem_addr = RESET_PC in the first clock cycle after rst_n deasserts.
- Fetch latency: grant at cycle N, rvalid at N+1 → inst_valid at N+2 (FIFO output is registered, no bypass).
- Sustained throughput is 1 instruction/cycle with 1-cycle memory and inst_ready held high.
- After redirect at cycle R: request to target at R+1; inst_valid for target no earlier than R+3.
- imem_addr is stable while imem_req = 1 and imem_gnt = 0.

## Configuration
- IFU_STATS_EN defined: adds output fetch_count (32-bit) and flush_count (16-bit), both reset to 0.
  - fetch_count increments on every completed inst handshake.
  - flush_count increments on every redirect_valid cycle.
  - Both wrap on overflow.
- IFU_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package riscv_pkg:
  - XLEN = 32
  - INST_BYTES = 4
  - fetch_entry_t struct {pc, inst}
- Sub-module fetch_buffer: 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush, occ, head. Flush has priority over push.

## Test plan
- Reset release, 1-cycle memory, inst_ready = 1 → addresses 0, 4, 8… requested on consecutive cycles. First inst_valid is 2 cycles after the first grant; then one instruction per cycle, with inst_pc matching.
- inst_ready = 0 for 10 cycles → at most 2 requests outstanding/buffered, imem_req drops. On release, instructions 0, 4 are delivered in order with no loss or duplicate.
- Redirect to 32'h0000_0100 with 2 responses in flight → both stale words dropped. Next inst_pc = 0x100, no earlier than R+3. imem_req is low in cycle R.
- Redirect in the same cycle as imem_rvalid and a pending inst_ready → no handshake occurs, the response is discarded, and only the target's stream follows.
- Two redirects on consecutive cycles (0x200, then 0x300) → only 0x300 fetched and delivered. redirect_pc = 0x303 → fetch 0x300.
- rst_n asserted mid-stream with the FIFO full → all outputs return to reset values immediately. Fetch resumes from RESET_PC after release. With IFU_STATS_EN defined, the counters read 0.
